control_actuadores: RTL and testbench

Actuator sequencer between the temperature monitor and the power drivers for the fan (ventilador) and heater (calefactor). Takes the monitor's raw fan/heater requests and drives the physical enables. Guarantees mutual exclusion, a dead time between actuators, minimum on/off times (anti-short-cycle) and a maximum continuous on-time with fault lockout.

---
 rtl/control_actuadores.sv | 151 +++++++++++++++
 tb/tb_control_actuadores.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/control_actuadores.sv
// Fan/heater actuator sequencer: mutual exclusion, dead time, min on/off, max on-time lockout.
// Optional statistics outputs enabled by defining CTRL_ACT_ESTADISTICAS_EN.
module control_actuadores #(
    parameter int unsigned T_MIN_ON  = 8,
    parameter int unsigned T_MIN_OFF = 16,
    parameter int unsigned T_MUERTO  = 4,
    parameter int unsigned T_MAX_ON  = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pide_ventilador,
    input  logic       pide_calefactor,
    output logic       en_ventilador,
    output logic       en_calefactor,
    output logic [2:0] estado,
    output logic       conflicto,
    output logic       falla
`ifdef CTRL_ACT_ESTADISTICAS_EN
    ,
    output logic [7:0] act_ventilador,
    output logic [7:0] act_calefactor,
    output logic [7:0] falla_cnt
`endif
);

    typedef enum logic [2:0] {
        REPOSO = 3'b000,
        VENT   = 3'b001,
        CALE   = 3'b010,
        MUERTO = 3'b011,
        FALLA  = 3'b100
    } estado_e;

    localparam logic [CNT_W-1:0] MIN_ON_M1 = CNT_W'(T_MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_ON_M1 = CNT_W'(T_MAX_ON - 1);
    localparam logic [CNT_W-1:0] MUERTO_M1 = CNT_W'(T_MUERTO - 1);
    localparam logic [CNT_W-1:0] MIN_OFF   = CNT_W'(T_MIN_OFF);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    estado_e          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] off_v_q, off_v_d;
    logic [CNT_W-1:0] off_c_q, off_c_d;
    logic             conflicto_q;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            REPOSO: begin
                if (pide_ventilador && !pide_calefactor && off_v_q >= MIN_OFF)
                    estado_d = VENT;
                else if (pide_calefactor && !pide_ventilador && off_c_q >= MIN_OFF)
                    estado_d = CALE;
            end
            VENT: begin
                if (pide_ventilador && cnt_q == MAX_ON_M1)
                    estado_d = FALLA;
                else if (!pide_ventilador && cnt_q >= MIN_ON_M1)
                    estado_d = MUERTO;
            end
            CALE: begin
                if (pide_calefactor && cnt_q == MAX_ON_M1)
                    estado_d = FALLA;
                else if (!pide_calefactor && cnt_q >= MIN_ON_M1)
                    estado_d = MUERTO;
            end
            MUERTO: begin
                if (cnt_q >= MUERTO_M1)
                    estado_d = REPOSO;
            end
            FALLA: begin
                if (!pide_ventilador && !pide_calefactor &&
                    off_v_q >= MIN_OFF && off_c_q >= MIN_OFF)
                    estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // State counter restarts on every transition and saturates otherwise.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (estado_d != estado_q)
            cnt_d = '0;
    end

    // Off counters start at 1 on the turn-off edge, then count up to T_MIN_OFF while off.
    always_comb begin
        off_v_d = off_v_q;
        off_c_d = off_c_q;
        if (estado_q == VENT) begin
            if (estado_d != VENT)
                off_v_d = CNT_W'(1);
        end else if (off_v_q < MIN_OFF) begin
            off_v_d = off_v_q + 1'b1;
        end
        if (estado_q == CALE) begin
            if (estado_d != CALE)
                off_c_d = CNT_W'(1);
        end else if (off_c_q < MIN_OFF) begin
            off_c_d = off_c_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q    <= REPOSO;
            cnt_q       <= '0;
            off_v_q     <= MIN_OFF;
            off_c_q     <= MIN_OFF;
            conflicto_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            off_v_q     <= off_v_d;
            off_c_q     <= off_c_d;
            conflicto_q <= pide_ventilador & pide_calefactor;
        end
    end

    assign estado        = estado_q;
    assign en_ventilador = (estado_q == VENT);
    assign en_calefactor = (estado_q == CALE);
    assign falla         = (estado_q == FALLA);
    assign conflicto     = conflicto_q;

`ifdef CTRL_ACT_ESTADISTICAS_EN
    logic [7:0] act_v_q, act_c_q, falla_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            act_v_q     <= '0;
            act_c_q     <= '0;
            falla_cnt_q <= '0;
        end else begin
            if (estado_q != VENT && estado_d == VENT && act_v_q != 8'hFF)
                act_v_q <= act_v_q + 1'b1;
            if (estado_q != CALE && estado_d == CALE && act_c_q != 8'hFF)
                act_c_q <= act_c_q + 1'b1;
            if (estado_q != FALLA && estado_d == FALLA && falla_cnt_q != 8'hFF)
                falla_cnt_q <= falla_cnt_q + 1'b1;
        end
    end

    assign act_ventilador = act_v_q;
    assign act_calefactor = act_c_q;
    assign falla_cnt      = falla_cnt_q;
`endif

endmodule

// File: tb/tb_control_actuadores.sv
// Directed self-checking bench for control_actuadores (default parameters).
module tb_control_actuadores;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       pv = 1'b0;
    logic       pc = 1'b0;
    logic       en_v, en_c, conflicto, falla;
    logic [2:0] estado;
`ifdef CTRL_ACT_ESTADISTICAS_EN
    logic [7:0] act_v, act_c, falla_cnt;
`endif

    int errors = 0;
    int checks = 0;

    control_actuadores #(
        .T_MIN_ON (8),
        .T_MIN_OFF(16),
        .T_MUERTO (4),
        .T_MAX_ON (64),
        .CNT_W    (16)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .pide_ventilador(pv),
        .pide_calefactor(pc),
        .en_ventilador  (en_v),
        .en_calefactor  (en_c),
        .estado         (estado),
        .conflicto      (conflicto),
        .falla          (falla)
`ifdef CTRL_ACT_ESTADISTICAS_EN
        ,
        .act_ventilador (act_v),
        .act_calefactor (act_c),
        .falla_cnt      (falla_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int e, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic cyc(input logic v, input logic c);
        pv = v;
        pc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pv = 1'b0;
        pc = 1'b0;
        arst_n = 1'b0;
        #2;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    logic [2:0] exp_st;
    int         lowcnt;

    initial begin
        // Reset state
        #3;
        chk("rst_estado", -1, 16'(estado), 16'd0);
        chk("rst_en_v", -1, 16'(en_v), 16'd0);
        chk("rst_en_c", -1, 16'(en_c), 16'd0);
        chk("rst_falla", -1, 16'(falla), 16'd0);
        chk("rst_conflicto", -1, 16'(conflicto), 16'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Reset in the middle of VENT
        for (int e = 0; e <= 4; e++) cyc(1'b1, 1'b0);
        chk("midrst_pre_en_v", 4, 16'(en_v), 16'd1);
        arst_n = 1'b0;
        #2;
        chk("midrst_en_v", 4, 16'(en_v), 16'd0);
        chk("midrst_estado", 4, 16'(estado), 16'd0);
        chk("midrst_falla", 4, 16'(falla), 16'd0);
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b1, 1'b0);
        chk("midrst_served", 0, 16'(estado), 16'd1);

        // Short request: minimum on-time, dead time, back to idle
        do_reset();
        for (int e = 0; e <= 14; e++) begin
            cyc(e <= 2, 1'b0);
            exp_st = (e <= 7) ? 3'd1 : (e <= 11) ? 3'd3 : 3'd0;
            chk("minon_estado", e, 16'(estado), 16'(exp_st));
            chk("minon_en_v", e, 16'(en_v), 16'(e <= 7));
        end

        // Fan then heater handover
        do_reset();
        for (int e = 0; e <= 30; e++) begin
            cyc(e <= 19, e >= 20);
            exp_st = (e <= 19) ? 3'd1 : (e <= 23) ? 3'd3 : (e == 24) ? 3'd0 : 3'd2;
            chk("hand_estado", e, 16'(estado), 16'(exp_st));
            chk("hand_en_c", e, 16'(en_c), 16'(e >= 25));
            chk("hand_excl", e, 16'(en_v & en_c), 16'd0);
        end

        // Max on-time fault and lockout release
        do_reset();
        for (int e = 0; e <= 82; e++) begin
            cyc(e < 70, 1'b0);
            exp_st = (e <= 63) ? 3'd1 : (e <= 79) ? 3'd4 : 3'd0;
            chk("maxon_estado", e, 16'(estado), 16'(exp_st));
            chk("maxon_falla", e, 16'(falla), 16'(e >= 64 && e <= 79));
            chk("maxon_en_v", e, 16'(en_v), 16'(e <= 63));
        end
`ifdef CTRL_ACT_ESTADISTICAS_EN
        chk("falla_cnt", 82, 16'(falla_cnt), 16'd1);
`endif

        // Both requests in idle
        do_reset();
        for (int e = 0; e <= 2; e++) begin
            cyc(1'b1, 1'b1);
            chk("conf_flag", e, 16'(conflicto), 16'd1);
            chk("conf_estado", e, 16'(estado), 16'd0);
            chk("conf_en", e, 16'({en_v, en_c}), 16'd0);
        end
        cyc(1'b0, 1'b0);
        chk("conf_clear", 3, 16'(conflicto), 16'd0);

        // Heater request while fan runs is ignored
        do_reset();
        for (int e = 0; e <= 6; e++) begin
            cyc(1'b1, e == 3 || e == 4);
            chk("vconf_estado", e, 16'(estado), 16'd1);
            chk("vconf_flag", e, 16'(conflicto), 16'(e == 3 || e == 4));
            chk("vconf_en_c", e, 16'(en_c), 16'd0);
        end

        // Immediate re-request: anti-short-cycle off time
        do_reset();
        lowcnt = 0;
        for (int e = 0; e <= 26; e++) begin
            cyc(e != 8, 1'b0);
            exp_st = (e <= 7) ? 3'd1 : (e <= 11) ? 3'd3 : (e <= 23) ? 3'd0 : 3'd1;
            chk("rereq_estado", e, 16'(estado), 16'(exp_st));
            if (!en_v) lowcnt++;
        end
        chk("rereq_lowcnt", 26, 16'(lowcnt), 16'd16);
`ifdef CTRL_ACT_ESTADISTICAS_EN
        chk("act_ventilador", 26, 16'(act_v), 16'd2);
        chk("act_calefactor", 26, 16'(act_c), 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
